// File: rtl/zint_sched.sv
// zint_sched: turns raster position and DMA completion into 1-clk INT start
// strobes for the Z80 ~INT generator.
// Optional feature macro ZSCHED_LINE_DIV_EN: adds line_div[3:0] so that the
// line INT fires only on every (line_div+1)-th qualifying line.
module zint_sched #(
    parameter int VW        = 9,
    parameter int HW        = 8,
    parameter int VLINES    = 320,
    parameter int LINE_HPOS = 0
) (
    input  logic          clk,
    input  logic          res,
    input  logic          frame_start,
    input  logic [VW-1:0] vcnt,
    input  logic [HW-1:0] hcnt,
    input  logic          cfg_we,
    input  logic [VW-1:0] cfg_vpos,
    input  logic [HW-1:0] cfg_hpos,
    input  logic          line_en,
    input  logic          dma_busy,
`ifdef ZSCHED_LINE_DIV_EN
    input  logic [3:0]    line_div,
`endif
    output logic          int_start_frm,
    output logic          int_start_lin,
    output logic          int_start_dma,
    output logic          frm_pending
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRED} frm_state_t;

    localparam logic [VW:0]   VLINES_W    = VLINES[VW:0];
    localparam logic [HW-1:0] LINE_HPOS_W = LINE_HPOS[HW-1:0];

    frm_state_t    state, state_nxt;
    logic [VW-1:0] pend_vpos, shad_vpos, eff_vpos;
    logic [HW-1:0] pend_hpos, shad_hpos, eff_hpos;
    logic          in_range, pos_match, fire_frm;
    logic          at_hpos, at_hpos_r, lin_evt, fire_lin;
    logic [VW-1:0] vcnt_r;
    logic          dma_busy_r, fire_dma;

    assign in_range = ({1'b0, vcnt} < VLINES_W);

    // Position compared this clk: on frame_start the freshly loaded shadow
    // (a same-clk write bypasses the pending register), otherwise the shadow.
    always_comb begin
        eff_vpos = shad_vpos;
        eff_hpos = shad_hpos;
        if (frame_start) begin
            eff_vpos = cfg_we ? cfg_vpos : pend_vpos;
            eff_hpos = cfg_we ? cfg_hpos : pend_hpos;
        end
    end

    // An out-of-range shadow line can only equal an out-of-range vcnt,
    // so the in_range term silently blocks it.
    assign pos_match = in_range && (vcnt == eff_vpos) && (hcnt == eff_hpos);

    // Pending config and per-frame shadow registers.
    always_ff @(posedge clk) begin
        if (res) begin
            pend_vpos <= '0;
            pend_hpos <= '0;
            shad_vpos <= '0;
            shad_hpos <= '0;
        end else begin
            if (cfg_we) begin
                pend_vpos <= cfg_vpos;
                pend_hpos <= cfg_hpos;
            end
            if (frame_start) begin
                shad_vpos <= eff_vpos;
                shad_hpos <= eff_hpos;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (res) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Frame FSM next state; fire_frm is the matching clk, strobe follows.
    always_comb begin
        state_nxt = state;
        fire_frm  = 1'b0;
        case (state)
            S_IDLE, S_FIRED: begin
                if (frame_start) begin
                    if (pos_match) begin
                        state_nxt = S_FIRED;
                        fire_frm  = 1'b1;
                    end else begin
                        state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                // frame_start without a match just reloads the shadow.
                if (pos_match) begin
                    state_nxt = S_FIRED;
                    fire_frm  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign frm_pending = (state == S_ARMED);

    // Line event fires once per line: an hcnt stall on LINE_HPOS with the
    // same vcnt is treated as the same line.
    assign at_hpos = (hcnt == LINE_HPOS_W);
    assign lin_evt = at_hpos && in_range && line_en && !(at_hpos_r && (vcnt == vcnt_r));

    // History used to suppress retriggering on a stalled hcnt.
    always_ff @(posedge clk) begin
        if (res) begin
            at_hpos_r <= 1'b0;
            vcnt_r    <= '0;
        end else begin
            at_hpos_r <= at_hpos;
            vcnt_r    <= vcnt;
        end
    end

`ifdef ZSCHED_LINE_DIV_EN
    logic [3:0] lcnt, div_act, eff_lcnt, eff_div;

    // frame_start clears the counter in the same clk as line 0's event.
    always_comb begin
        eff_lcnt = frame_start ? 4'd0 : lcnt;
        eff_div  = frame_start ? line_div : div_act;
    end

    assign fire_lin = lin_evt && (eff_lcnt == 4'd0);

    // Line divider; a new line_div is taken only when the counter wraps.
    always_ff @(posedge clk) begin
        if (res) begin
            lcnt    <= 4'd0;
            div_act <= 4'd0;
        end else if (lin_evt) begin
            if (eff_lcnt >= eff_div) begin
                lcnt    <= 4'd0;
                div_act <= line_div;
            end else begin
                lcnt    <= eff_lcnt + 4'd1;
                div_act <= eff_div;
            end
        end else if (frame_start) begin
            lcnt    <= 4'd0;
            div_act <= line_div;
        end
    end
`else
    assign fire_lin = lin_evt;
`endif

    assign fire_dma = dma_busy_r & ~dma_busy;

    // Registered strobes; a reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            dma_busy_r    <= 1'b0;
            int_start_frm <= 1'b0;
            int_start_lin <= 1'b0;
            int_start_dma <= 1'b0;
        end else begin
            dma_busy_r    <= dma_busy;
            int_start_frm <= fire_frm;
            int_start_lin <= fire_lin;
            int_start_dma <= fire_dma;
        end
    end

endmodule

// File: tb/tb_zint_sched.sv
// Directed self-checking bench for zint_sched (VLINES=320, LINE_HPOS=0).
// Frames are compressed: each line presents hcnt 0..hmax-1 only.
module tb_zint_sched;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       frame_start = 1'b0;
    logic [8:0] vcnt = '0;
    logic [7:0] hcnt = '0;
    logic       cfg_we = 1'b0;
    logic [8:0] cfg_vpos = '0;
    logic [7:0] cfg_hpos = '0;
    logic       line_en = 1'b0;
    logic       dma_busy = 1'b0;
`ifdef ZSCHED_LINE_DIV_EN
    logic [3:0] line_div = 4'd0;
`endif
    logic       int_start_frm, int_start_lin, int_start_dma, frm_pending;

    int n_cmp = 0;
    int n_bad = 0;
    int frm_n, lin_n, dma_n;
    int frm_v, frm_h;
    logic pend_after_fs;

    zint_sched #(.VW(9), .HW(8), .VLINES(320), .LINE_HPOS(0)) dut (
        .clk(clk), .res(res), .frame_start(frame_start), .vcnt(vcnt), .hcnt(hcnt),
        .cfg_we(cfg_we), .cfg_vpos(cfg_vpos), .cfg_hpos(cfg_hpos),
        .line_en(line_en), .dma_busy(dma_busy),
`ifdef ZSCHED_LINE_DIV_EN
        .line_div(line_div),
`endif
        .int_start_frm(int_start_frm), .int_start_lin(int_start_lin),
        .int_start_dma(int_start_dma), .frm_pending(frm_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1, "timeout");
    end

    // One clock with current inputs; strobes sampled just after the edge
    // belong to the position that was presented.
    task automatic step();
        @(posedge clk);
        #1;
        if (int_start_frm) begin
            frm_n++;
            frm_v = int'(vcnt);
            frm_h = int'(hcnt);
        end
        lin_n += int'(int_start_lin);
        dma_n += int'(int_start_dma);
    endtask

    task automatic clr();
        frm_n = 0; lin_n = 0; dma_n = 0; frm_v = -1; frm_h = -1;
    endtask

    task automatic cfg_write(input int v, input int h);
        cfg_we = 1'b1; cfg_vpos = 9'(v); cfg_hpos = 8'(h);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_frame(input bit fs, input int nlines, input int hmax,
                             input int we_line, input int we_v);
        clr();
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < hmax; h++) begin
                vcnt = 9'(v);
                hcnt = 8'(h);
                frame_start = fs && v == 0 && h == 0;
                cfg_we = (v == we_line) && (h == 0);
                if (cfg_we) cfg_vpos = 9'(we_v);
                step();
                if (v == 0 && h == 0) pend_after_fs = frm_pending;
            end
        end
        frame_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; line_en = 1'b1; dma_busy = 1'b0;
        clr();
        step(); step();
        n_cmp++; if (frm_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", frm_pending); end
        n_cmp++; if ({int_start_frm, int_start_lin, int_start_dma} !== 3'b000) begin n_bad++;
            $display("FAIL reset_strobes: got %b want 000", {int_start_frm, int_start_lin, int_start_dma}); end
        res = 1'b0; vcnt = 9'd329; hcnt = 8'd23; line_en = 1'b0;
        step();
    endtask

    task automatic test_frame_int();
        cfg_write(100, 20);
        line_en = 1'b1;
        run_frame(1, 330, 24, -1, 0);
        n_cmp++; if (pend_after_fs !== 1'b1) begin n_bad++; $display("FAIL frm_armed: got %b want 1", pend_after_fs); end
        n_cmp++; if (frm_n != 1) begin n_bad++; $display("FAIL frm_count: got %0d want 1", frm_n); end
        n_cmp++; if (frm_v != 100 || frm_h != 20) begin n_bad++; $display("FAIL frm_pos: got %0d,%0d want 100,20", frm_v, frm_h); end
        n_cmp++; if (lin_n != 320) begin n_bad++; $display("FAIL lin_count: got %0d want 320", lin_n); end
        n_cmp++; if (frm_pending !== 1'b0) begin n_bad++; $display("FAIL frm_fired_pending: got %b want 0", frm_pending); end
    endtask

    task automatic test_no_refire();
        line_en = 1'b0;
        run_frame(0, 330, 24, -1, 0);
        n_cmp++; if (frm_n != 0) begin n_bad++; $display("FAIL no_refire: got %0d want 0", frm_n); end
        n_cmp++; if (lin_n != 0) begin n_bad++; $display("FAIL lin_disabled: got %0d want 0", lin_n); end
    endtask

    task automatic test_shadow();
        cfg_write(200, 20);
        line_en = 1'b1;
        run_frame(1, 330, 24, 10, 50);
        n_cmp++; if (frm_n != 1 || frm_v != 200) begin n_bad++; $display("FAIL shadow_cur: got n=%0d v=%0d want n=1 v=200", frm_n, frm_v); end
        run_frame(1, 330, 24, -1, 0);
        n_cmp++; if (frm_n != 1 || frm_v != 50 || frm_h != 20) begin n_bad++;
            $display("FAIL shadow_next: got n=%0d v=%0d h=%0d want n=1 v=50 h=20", frm_n, frm_v, frm_h); end
    endtask

    task automatic test_out_of_range();
        cfg_write(320, 2);
        run_frame(1, 330, 4, -1, 0);
        n_cmp++; if (frm_n != 0) begin n_bad++; $display("FAIL oor_fire: got %0d want 0", frm_n); end
        n_cmp++; if (frm_pending !== 1'b1) begin n_bad++; $display("FAIL oor_pending: got %b want 1", frm_pending); end
        n_cmp++; if (lin_n != 320) begin n_bad++; $display("FAIL oor_lin_count: got %0d want 320", lin_n); end
    endtask

    task automatic test_line_stall();
        clr();
        line_en = 1'b1; vcnt = 9'd7; hcnt = 8'd3;
        step();
        hcnt = 8'd0;
        repeat (5) step();
        n_cmp++; if (lin_n != 1) begin n_bad++; $display("FAIL lin_stall: got %0d want 1", lin_n); end
        vcnt = 9'd8;
        step();
        n_cmp++; if (lin_n != 2) begin n_bad++; $display("FAIL lin_rearm: got %0d want 2", lin_n); end
        hcnt = 8'd5;
        step();
    endtask

    task automatic test_dma();
        clr();
        dma_busy = 1'b1; step();
        dma_busy = 1'b0; step();
        n_cmp++; if (int_start_dma !== 1'b1) begin n_bad++; $display("FAIL dma_short: got %b want 1", int_start_dma); end
        step();
        n_cmp++; if (int_start_dma !== 1'b0) begin n_bad++; $display("FAIL dma_single: got %b want 0", int_start_dma); end
        dma_busy = 1'b1; repeat (40) step();
        dma_busy = 1'b0; step();
        n_cmp++; if (int_start_dma !== 1'b1) begin n_bad++; $display("FAIL dma_long: got %b want 1", int_start_dma); end
        step(); step();
        n_cmp++; if (dma_n != 2) begin n_bad++; $display("FAIL dma_count: got %0d want 2", dma_n); end
    endtask

    task automatic test_collision();
        vcnt = 9'd329; hcnt = 8'd5;
        cfg_write(0, 0);
        line_en = 1'b1; dma_busy = 1'b1;
        step();
        frame_start = 1'b1; vcnt = 9'd0; hcnt = 8'd0; dma_busy = 1'b0;
        step();
        n_cmp++; if ({int_start_frm, int_start_lin, int_start_dma} !== 3'b111) begin n_bad++;
            $display("FAIL collision: got %b want 111", {int_start_frm, int_start_lin, int_start_dma}); end
        frame_start = 1'b0; hcnt = 8'd1;
        step();
        n_cmp++; if ({int_start_frm, int_start_lin, int_start_dma} !== 3'b000) begin n_bad++;
            $display("FAIL collision_after: got %b want 000", {int_start_frm, int_start_lin, int_start_dma}); end
    endtask

    task automatic test_reset_mid();
        vcnt = 9'd329; hcnt = 8'd5;
        cfg_write(5, 1);
        frame_start = 1'b1; vcnt = 9'd0; hcnt = 8'd0;
        step();
        frame_start = 1'b0;
        n_cmp++; if (frm_pending !== 1'b1) begin n_bad++; $display("FAIL mid_armed: got %b want 1", frm_pending); end
        clr();
        vcnt = 9'd5; hcnt = 8'd1; res = 1'b1;
        step();
        res = 1'b0;
        n_cmp++; if (int_start_frm !== 1'b0 || frm_pending !== 1'b0) begin n_bad++;
            $display("FAIL mid_reset: got frm=%b pend=%b want 0 0", int_start_frm, frm_pending); end
        hcnt = 8'd0; step();
        hcnt = 8'd1; step();
        hcnt = 8'd2; step();
        n_cmp++; if (frm_n != 0) begin n_bad++; $display("FAIL mid_no_fire: got %0d want 0", frm_n); end
        // reset cleared the config, so the next frame arms at (0,0) and fires at once
        frame_start = 1'b1; vcnt = 9'd0; hcnt = 8'd0;
        step();
        frame_start = 1'b0; hcnt = 8'd1;
        step();
        n_cmp++; if (frm_n != 1 || frm_v != 0 || frm_h != 0) begin n_bad++;
            $display("FAIL mid_rearm: got n=%0d v=%0d h=%0d want n=1 v=0 h=0", frm_n, frm_v, frm_h); end
        vcnt = 9'd329; hcnt = 8'd23;
        step();
    endtask

`ifdef ZSCHED_LINE_DIV_EN
    task automatic test_line_div();
        line_div = 4'd3; line_en = 1'b1;
        run_frame(1, 330, 4, -1, 0);
        n_cmp++; if (lin_n != 80) begin n_bad++; $display("FAIL line_div3: got %0d want 80", lin_n); end
        line_div = 4'd0;
        run_frame(1, 330, 4, -1, 0);
        n_cmp++; if (lin_n != 320) begin n_bad++; $display("FAIL line_div0: got %0d want 320", lin_n); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_int();
        test_no_refire();
        test_shadow();
        test_out_of_range();
        test_line_stall();
        test_dma();
        test_collision();
        test_reset_mid();
`ifdef ZSCHED_LINE_DIV_EN
        test_line_div();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
